// File: rtl/instruction_buffer_pkg.sv
// instruction_buffer_pkg
//   Shared definitions for the fetch->decode instruction buffer.
//   - NOP_INSTRUCTION : word presented to decode when no entry is valid
//   - ptr_width()     : index width for a storage array of a given depth
//   - entry_t         : {PC, instruction} pair at the default core widths
//                       (16-bit PC, 32-bit instruction)
package instruction_buffer_pkg;

  localparam int PC_BITS    = 16;
  localparam int INSTR_BITS = 32;

  // addi x0, x0, 0
  localparam logic [INSTR_BITS-1:0] NOP_INSTRUCTION = 32'h00000013;

  typedef struct packed {
    logic [PC_BITS-1:0]    pc;
    logic [INSTR_BITS-1:0] instruction;
  } entry_t;

  // A depth of 1 would give a zero-width pointer; clamp to one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/instruction_buffer_storage.sv
// instruction_buffer_storage
//   Entry array for the instruction buffer: one synchronous write port and
//   one asynchronous (combinational) read port, both addressed by pointer.
//   Contents are never reset; validity is tracked by the owner's count.
//   Ports:
//     clock   : rising-edge clock
//     wr_en   : write wr_data into slot wr_ptr on the edge
//     wr_ptr  : write index
//     wr_data : entry to store
//     rd_ptr  : read index
//     rd_data : entry at rd_ptr (combinational)
module instruction_buffer_storage #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/instruction_buffer.sv
// instruction_buffer
//   Small circular FIFO of {PC, instruction} pairs between fetch and decode.
//   Valid/ready on both sides; flush (fetch redirect) empties the buffer.
//   in_ready depends only on registered occupancy, so fetch can use it as
//   its PC hold without any combinational path from decode.
//   Optional build macro: INSTR_BUFFER_BYPASS_EN
//     When defined, an empty buffer forwards the incoming pair to decode in
//     the same cycle (0-cycle latency); if decode takes it, it is never
//     written. When undefined, minimum latency is one cycle.
//   Ports:
//     clock, reset          : rising-edge clock, async active-high reset
//     flush                 : discard all entries (priority over push/pop)
//     in_valid/in_ready     : fetch-side handshake
//     in_PC, in_instruction : incoming pair
//     out_valid/out_ready   : decode-side handshake
//     out_PC, out_instruction : head pair (0 / NOP when out_valid is low)
//     count                 : occupancy, 0..DEPTH
module instruction_buffer
  import instruction_buffer_pkg::*;
#(
  parameter int ADDRESS_BITS = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [ADDRESS_BITS-1:0]    in_PC,
  input  logic [DATA_WIDTH-1:0]      in_instruction,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [ADDRESS_BITS-1:0]    out_PC,
  output logic [DATA_WIDTH-1:0]      out_instruction,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Local view of an entry at this instance's widths.
  typedef struct packed {
    logic [ADDRESS_BITS-1:0] pc;
    logic [DATA_WIDTH-1:0]   instruction;
  } slot_t;

  localparam int SLOT_W = $bits(slot_t);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  slot_t wr_slot;
  slot_t rd_slot;
  slot_t head;

  logic not_empty;
  logic wr_en;
  logic rd_en;

  assign wr_slot   = '{pc: in_PC, instruction: in_instruction};
  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q != CNT_W'(DEPTH));

`ifdef INSTR_BUFFER_BYPASS_EN
  logic bypass;

  // Empty buffer with a live pair and no redirect: show it to decode now.
  assign bypass    = !not_empty && in_valid && !flush;
  assign out_valid = not_empty || bypass;
  assign head      = bypass ? wr_slot : rd_slot;
  // A bypassed pair that decode accepts is consumed directly, never stored.
  assign wr_en     = in_valid && in_ready && !(bypass && out_ready);
  assign rd_en     = not_empty && out_ready;
`else
  assign out_valid = not_empty;
  assign head      = rd_slot;
  assign wr_en     = in_valid && in_ready;
  assign rd_en     = not_empty && out_ready;
`endif

  assign out_PC          = out_valid ? head.pc : '0;
  assign out_instruction = out_valid ? head.instruction
                                     : DATA_WIDTH'(NOP_INSTRUCTION);
  assign count           = count_q;

  instruction_buffer_storage #(
    .WIDTH (SLOT_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_storage (
    .clock   (clock),
    .wr_en   (wr_en && !flush),
    .wr_ptr  (wr_ptr),
    .wr_data (wr_slot),
    .rd_ptr  (rd_ptr),
    .rd_data (rd_slot)
  );

  // Pointer / occupancy update; full vs empty is decided by count only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

endmodule
